// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with PC, direct-mapped one-word-per-line
// instruction cache and a request/ready miss handshake to memory.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   rdy                 global enable; low freezes all state
//   stall_state[5:0]    bit 1 high -> IF/ID holding, PC must hold
//   b_flag_i/b_target_i branch redirect (pulse) and its target
//   mem_if_rdy_i/_inst_i memory return pulse and returned word
//   if_mem_req_o/_addr_o registered fetch request and address
//   if_pc/if_inst       PC and its instruction (0 unless hit)
//   if_stall_req        high while IF cannot supply an instruction
module if_fetch #(
  parameter int ICACHE_INDEX_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [5:0]  stall_state,
  input  logic        b_flag_i,
  input  logic [31:0] b_target_i,
  input  logic        mem_if_rdy_i,
  input  logic [31:0] mem_if_inst_i,
  output logic        if_mem_req_o,
  output logic [31:0] if_mem_addr_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_stall_req
);

  localparam int IW      = ICACHE_INDEX_W;
  localparam int TW      = 32 - IW - 2;
  localparam int ENTRIES = 1 << IW;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state_q;
  logic [31:0]       pc_q;
  logic              req_q;
  logic [31:0]       addr_q;
  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]     tag_q  [ENTRIES];
  logic [31:0]       data_q [ENTRIES];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          hit;
  logic          fill;

  assign idx      = pc_q[IW+1:2];
  assign tag      = pc_q[31:IW+2];
  // Fills are keyed off the latched request address; the PC may have been
  // redirected while the request was outstanding.
  assign fill_idx = addr_q[IW+1:2];
  assign fill_tag = addr_q[31:IW+2];

  assign hit  = valid_q[idx] && (tag_q[idx] == tag) && (state_q == S_IDLE);
  assign fill = rdy && (state_q == S_WAIT) && mem_if_rdy_i;

  assign if_pc         = pc_q;
  assign if_inst       = hit ? data_q[idx] : 32'h0;
  assign if_stall_req  = rst ? 1'b0 : !hit;
  assign if_mem_req_o  = req_q;
  assign if_mem_addr_o = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 32'h0;
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
      valid_q <= '0;
    end else if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (!hit) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        S_WAIT: begin
          if (mem_if_rdy_i) begin
            state_q           <= S_IDLE;
            req_q             <= 1'b0;
            valid_q[fill_idx] <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (b_flag_i)
        pc_q <= b_target_i;
      else if (stall_state[1])
        pc_q <= pc_q;
      else if (hit)
        pc_q <= pc_q + 32'd4;
    end
  end

  // Data and tag arrays carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      data_q[fill_idx] <= mem_if_inst_i;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall_state;
  logic        b_flag_i;
  logic [31:0] b_target_i;
  logic        mem_if_rdy_i;
  logic [31:0] mem_if_inst_i;
  logic        if_mem_req_o;
  logic [31:0] if_mem_addr_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_stall_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch #(.ICACHE_INDEX_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .stall_state  (stall_state),
    .b_flag_i     (b_flag_i),
    .b_target_i   (b_target_i),
    .mem_if_rdy_i (mem_if_rdy_i),
    .mem_if_inst_i(mem_if_inst_i),
    .if_mem_req_o (if_mem_req_o),
    .if_mem_addr_o(if_mem_addr_o),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_stall_req (if_stall_req)
  );

  typedef struct {
    logic        rdy;
    logic        stall;
    logic        bf;
    logic [31:0] bt;
    logic        mr;
    logic [31:0] mi;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        stl;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic st, input logic bf, input logic [31:0] bt,
                     input logic mr, input logic [31:0] mi,
                     input logic [31:0] pc, input logic [31:0] inst, input logic stl,
                     input logic req, input logic [31:0] addr);
    vec_t v;
    v.rdy = r; v.stall = st; v.bf = bf; v.bt = bt; v.mr = mr; v.mi = mi;
    v.pc = pc; v.inst = inst; v.stl = stl; v.req = req; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d: got %h, want %h", name, row, got, want);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, advance to next negedge.
  task automatic apply_row(input vec_t v, input int row);
    rdy           = v.rdy;
    stall_state   = {4'b0, v.stall, 1'b0};
    b_flag_i      = v.bf;
    b_target_i    = v.bt;
    mem_if_rdy_i  = v.mr;
    mem_if_inst_i = v.mi;
    #1;
    chk("if_pc",         row, if_pc,                 v.pc);
    chk("if_inst",       row, if_inst,               v.inst);
    chk("if_stall_req",  row, {31'b0, if_stall_req}, {31'b0, v.stl});
    chk("if_mem_req_o",  row, {31'b0, if_mem_req_o}, {31'b0, v.req});
    chk("if_mem_addr_o", row, if_mem_addr_o,         v.addr);
    @(negedge clk);
  endtask

  localparam logic [31:0] I0   = 32'h0000_0013;
  localparam logic [31:0] I4   = 32'h1000_0004;
  localparam logic [31:0] I8   = 32'h1000_0008;
  localparam logic [31:0] I100 = 32'h1000_0100;
  localparam logic [31:0] I200 = 32'h1000_0200;

  initial begin
    vec_t v;
    rst = 1'b1; rdy = 1'b1; stall_state = '0; b_flag_i = 0; b_target_i = '0;
    mem_if_rdy_i = 0; mem_if_inst_i = '0;

    //   rdy st bf bt          mr mi            pc          inst  stl req addr
    // cold start: miss at 0, memory answers in 3rd request cycle
    add(1, 0, 0, 0,          0, 0,            32'h0,   0,    1, 0, 32'h0);
    add(1, 0, 0, 0,          0, 0,            32'h0,   0,    1, 1, 32'h0);
    add(1, 0, 0, 0,          0, 0,            32'h0,   0,    1, 1, 32'h0);
    add(1, 0, 0, 0,          1, I0,           32'h0,   0,    1, 1, 32'h0);
    add(1, 0, 0, 0,          0, 0,            32'h0,   I0,   0, 0, 32'h0);
    // prefill 0x4 and 0x8 with minimum-latency returns
    add(1, 0, 0, 0,          0, 0,            32'h4,   0,    1, 0, 32'h0);
    add(1, 0, 0, 0,          1, I4,           32'h4,   0,    1, 1, 32'h4);
    add(1, 0, 0, 0,          0, 0,            32'h4,   I4,   0, 0, 32'h4);
    add(1, 0, 0, 0,          0, 0,            32'h8,   0,    1, 0, 32'h4);
    add(1, 0, 0, 0,          1, I8,           32'h8,   0,    1, 1, 32'h8);
    add(1, 0, 1, 32'h0,      0, 0,            32'h8,   I8,   0, 0, 32'h8);
    // warm loop
    add(1, 0, 0, 0,          0, 0,            32'h0,   I0,   0, 0, 32'h8);
    add(1, 0, 0, 0,          0, 0,            32'h4,   I4,   0, 0, 32'h8);
    // stall hold window, branch inside it
    add(1, 1, 0, 0,          0, 0,            32'h8,   I8,   0, 0, 32'h8);
    add(1, 1, 0, 0,          0, 0,            32'h8,   I8,   0, 0, 32'h8);
    add(1, 1, 1, 32'h4,      0, 0,            32'h8,   I8,   0, 0, 32'h8);
    add(1, 1, 0, 0,          0, 0,            32'h4,   I4,   0, 0, 32'h8);
    // branch in WAIT
    add(1, 0, 1, 32'h100,    0, 0,            32'h4,   I4,   0, 0, 32'h8);
    add(1, 0, 0, 0,          0, 0,            32'h100, 0,    1, 0, 32'h8);
    add(1, 0, 1, 32'h0,      0, 0,            32'h100, 0,    1, 1, 32'h100);
    add(1, 0, 0, 0,          1, I100,         32'h0,   0,    1, 1, 32'h100);
    add(1, 0, 0, 0,          0, 0,            32'h0,   I0,   0, 0, 32'h100);
    add(1, 0, 1, 32'h100,    0, 0,            32'h4,   I4,   0, 0, 32'h100);
    // 0x100 hits with no request; then conflict at index 0
    add(1, 0, 1, 32'h200,    0, 0,            32'h100, I100, 0, 0, 32'h100);
    add(1, 0, 0, 0,          0, 0,            32'h200, 0,    1, 0, 32'h100);
    add(1, 0, 1, 32'h0,      1, I200,         32'h200, 0,    1, 1, 32'h200);
    add(1, 0, 0, 0,          0, 0,            32'h0,   0,    1, 0, 32'h200);
    // rdy low freezes and ignores memory return
    add(0, 0, 0, 0,          1, 32'hBAD,      32'h0,   0,    1, 1, 32'h0);
    add(1, 0, 0, 0,          1, I0,           32'h0,   0,    1, 1, 32'h0);
    add(1, 0, 0, 0,          0, 0,            32'h0,   I0,   0, 0, 32'h0);
    add(0, 0, 0, 0,          0, 0,            32'h4,   I4,   0, 0, 32'h0);
    add(1, 0, 1, 32'h200,    0, 0,            32'h4,   I4,   0, 0, 32'h0);
    add(1, 0, 0, 0,          0, 0,            32'h200, 0,    1, 0, 32'h0);
    add(1, 0, 0, 0,          0, 0,            32'h200, 0,    1, 1, 32'h200);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc",    -1, if_pc,                 32'h0);
    chk("rst_req",   -1, {31'b0, if_mem_req_o}, 32'h0);
    chk("rst_stall", -1, {31'b0, if_stall_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i], i);

    // reset mid-WAIT: request drops with no clock edge
    rst = 1'b1;
    #1;
    chk("rstw_req",   100, {31'b0, if_mem_req_o}, 32'h0);
    chk("rstw_addr",  100, if_mem_addr_o,         32'h0);
    chk("rstw_pc",    100, if_pc,                 32'h0);
    chk("rstw_stall", 100, {31'b0, if_stall_req}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // stray return in IDLE ignored; 0x0 and 0x4 both miss after reset
    v.rdy = 1; v.stall = 0; v.bf = 1; v.bt = 32'h4; v.mr = 1; v.mi = 32'hDEAD_BEEF;
    v.pc = 32'h0; v.inst = 0; v.stl = 1; v.req = 0; v.addr = 32'h0;
    apply_row(v, 101);
    v.bf = 0; v.bt = 0; v.mr = 1; v.mi = I0;
    v.pc = 32'h4; v.inst = 0; v.stl = 1; v.req = 1; v.addr = 32'h0;
    apply_row(v, 102);
    v.mr = 0; v.mi = 0;
    v.pc = 32'h4; v.inst = 0; v.stl = 1; v.req = 0; v.addr = 32'h0;
    apply_row(v, 103);
    v.mr = 1; v.mi = I4;
    v.pc = 32'h4; v.inst = 0; v.stl = 1; v.req = 1; v.addr = 32'h4;
    apply_row(v, 104);
    v.mr = 0; v.mi = 0;
    v.pc = 32'h4; v.inst = I4; v.stl = 0; v.req = 0; v.addr = 32'h4;
    apply_row(v, 105);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage: owns the program counter, looks up a direct-mapped instruction cache, and on a miss runs a request/ready handshake with the memory controller. It produces the `if_pc` / `if_inst` pair that the IF/ID pipeline register latches. It raises a stall request while a miss is outstanding and redirects the PC on a branch.

## Interface
Parameters:
- `ICACHE_INDEX_W`, default 7: index width; the cache holds 2^7 = 128 one-word entries.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rdy`  in  1  global enable; when low, every register holds and `mem_if_rdy_i` is ignored.
- `stall_state`  in  6  pipeline stall vector; bit 1 high means IF/ID is holding, so IF must hold its PC.
- `b_flag_i`  in  1  branch/jump taken; single-cycle pulse.
- `b_target_i`  in  32  redirect address, valid with `b_flag_i`.
- `mem_if_rdy_i`  in  1  memory controller has the requested word; single-cycle pulse.
- `mem_if_inst_i`  in  32  returned instruction word, valid with `mem_if_rdy_i`.
- `if_mem_req_o`  out  1  fetch request; registered.
- `if_mem_addr_o`  out  32  fetch address; registered.
- `if_pc`  out  32  current PC.
- `if_inst`  out  32  instruction at `if_pc` on a hit; otherwise 0.
- `if_stall_req`  out  1  IF cannot supply an instruction this cycle.

## Operation
- **Address split:**
  - index = `pc[ICACHE_INDEX_W+1:2]`
  - tag = `pc[31:ICACHE_INDEX_W+2]`
  - `pc[1:0]` is always 0.
- **Hit** (combinational) = valid[index] && tag match && state == IDLE.
- **Outputs** (combinational from state):
  - `if_pc` = pc.
  - `if_inst` = hit ? data[index] : 0.
  - `if_stall_req` = !hit.
  - While `rst` is high, `if_stall_req` is forced to 0.
- **FSM, two states, IDLE and WAIT:**
  - IDLE, hit: no memory activity.
  - IDLE, miss: go to WAIT; register `if_mem_addr_o` <= pc and `if_mem_req_o` <= 1.
  - WAIT: `if_mem_req_o` and `if_mem_addr_o` stay constant until `mem_if_rdy_i`.
  - On `mem_if_rdy_i` in WAIT:
    - Write data[addr index] <= `mem_if_inst_i`, set the tag and valid bit.
    - Set `if_mem_req_o` <= 0 and return to IDLE.
  - The fill always uses the latched `if_mem_addr_o`, never the current PC.
- **PC update** (when `rdy` is high), priority highest first:
  1. `b_flag_i` -> pc <= `b_target_i`, in any state and regardless of `stall_state`.
  2. `stall_state[1]` -> hold.
  3. hit -> pc <= pc + 4, with a 32-bit wrap (0xFFFFFFFC -> 0).
  4. Otherwise hold.
- **Branch during WAIT:**
  - The outstanding request is not cancelled. The FSM stays in WAIT until `mem_if_rdy_i`, and the returned word is still filled into the cache.
  - After returning to IDLE, lookup uses the new PC. That can hit immediately or start a new miss.
- **Simultaneous `mem_if_rdy_i` and `b_flag_i`:** both take effect. The fill completes, and pc <= target.
- **Fill and lookup in the same index:** a cycle that fills does not report a hit in that cycle (state is WAIT). The fill is visible from the next cycle.
- **Reset (asynchronous):**
  - pc = 0, state = IDLE, `if_mem_req_o` = 0, `if_mem_addr_o` = 0, all valid bits = 0.
  - The data and tag arrays are not reset.
  - Reset asserted in WAIT abandons the request immediately. Any `mem_if_rdy_i` arriving after reset is released while the FSM is in IDLE is ignored.

## Timing
- **Hit:** 0 cycles extra. One instruction per cycle, PC advances every clock unless stalled.
- **Miss**, detected in IDLE at cycle N:
  - `if_mem_req_o` goes high at N+1.
  - `mem_if_rdy_i` is accepted at any cycle M >= N+1.
  - The fill is written at the M edge; the hit and valid `if_inst` appear at M+1.
  - `if_stall_req` is high for cycles N..M inclusive.
  - `if_mem_req_o` is low from M+1.
- **Minimum miss penalty:** 2 cycles of stall (memory answering at N+1).
- **`rdy` low:** FSM, PC, request outputs and cache arrays are frozen. The combinational outputs still reflect the frozen state.

## Test plan
- **Cold start:** release reset with `mem_if_rdy_i` 3 cycles after the request, returning 0x00000013.
  - `if_mem_req_o`/`if_mem_addr_o` = 1/0x0 from N+1.
  - `if_stall_req` high 4 cycles.
  - Then `if_inst` = 0x00000013 at pc 0, pc -> 4 the next cycle.
- **Warm loop:** prefill 0x0, 0x4, 0x8, then branch to 0x0.
  - Three consecutive hits with `if_stall_req` = 0 and no `if_mem_req_o`.
  - pc sequence 0, 4, 8.
- **Branch in WAIT:** miss at 0x100, `b_flag_i` with target 0x0 (cached) one cycle later, then `mem_if_rdy_i`.
  - pc = 0 immediately.
  - Fill lands at index 0x40.
  - Hit at 0x0 the cycle after the return.
  - A later fetch of 0x100 hits with no request.
- **Stall hold:** `stall_state[1]` high for 3 cycles during hits.
  - pc and `if_inst` constant.
  - With `b_flag_i` inside the window, pc = target.
- **Conflict:** fill 0x0, then fetch 0x200 (same index 0, different tag).
  - A miss request is issued to 0x200.
  - The re-fetch of 0x0 misses again.
- **Reset mid-WAIT:** assert `rst` while `if_mem_req_o` is high.
  - Request drops without a clock edge.
  - All valid bits are cleared, so a previously cached 0x4 misses.
  - A stray `mem_if_rdy_i` after reset is released is ignored.
